// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone classic slave driving port 0 of a 512x32 SRAM wrapper; define WB_SRAM_ADDR_CHECK_EN for base-address checking with error termination
module wb_sram_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 9,
    parameter int          NUM_WMASKS = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0100_0000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [NUM_WMASKS-1:0] wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);
    typedef enum logic [1:0] {IDLE, RDWAIT, RESP} state_t;

    state_t state, state_nx;
    logic   req, hit, strobe, go, ack_nx, err_nx, cap;
    logic   unused_ok;

    assign req = wbs_cyc_i & wbs_stb_i;
`ifdef WB_SRAM_ADDR_CHECK_EN
    assign hit = wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
`else
    assign hit = 1'b1;
`endif
    assign unused_ok = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0], BASE_ADDR};

    // strobes are combinational in IDLE; reset forces the SRAM port idle at once
    assign go         = strobe & ~wb_rst_i;
    assign sram_csb   = ~go;
    assign sram_web   = ~(go & wbs_we_i);
    assign sram_wmask = (go & wbs_we_i) ? wbs_sel_i : '0;
    assign sram_addr  = wbs_adr_i[ADDR_WIDTH+1:2];
    assign sram_din   = wbs_dat_i;

    // next state, SRAM strobe, and registered-response decisions
    always_comb begin
        state_nx = state;
        strobe   = 1'b0;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        cap      = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (hit) begin
                    strobe   = 1'b1;
                    ack_nx   = wbs_we_i;
                    state_nx = wbs_we_i ? RESP : RDWAIT;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = RESP;
                end
            end
            RDWAIT: if (wbs_cyc_i) begin
                cap      = 1'b1;
                ack_nx   = 1'b1;
                state_nx = RESP;
            end else begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state, one-cycle ack/err pulses and read data capture
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            state     <= state_nx;
            wbs_ack_o <= ack_nx;
            wbs_err_o <= err_nx;
            if (cap) wbs_dat_o <= sram_dout;
        end
    end
endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb_wb_sram_ctrl: randomized transaction bench with a cycle-keyed expectation model and an SRAM behavioural model
module tb_wb_sram_ctrl;
    typedef struct packed {
        logic       web;
        logic [3:0] wmask;
        logic [8:0] addr;
        logic [31:0] din;
    } strobe_t;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic        wbs_ack_o, wbs_err_o;
    logic [31:0] wbs_dat_o;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [8:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'h0;

    logic [31:0] mem [512] = '{default: 32'h0};
    logic [31:0] ref_mem [512] = '{default: 32'h0};
    strobe_t     exp_strobe [int];
    bit          exp_ack [int];
    bit          exp_err [int];
    logic [31:0] exp_rd [int];
    logic [31:0] last_rd = 32'h0;
    int          cyc_n = 0;
    int          checks = 0, errors = 0;
    bit          chk_en = 1'b0;
    logic        p_csb, p_web;
    logic [3:0]  p_wmask;
    logic [8:0]  p_addr;
    int          lat;

    wb_sram_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // SRAM macro: masked write, or read data valid the cycle after the strobe
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] adr);
`ifdef WB_SRAM_ADDR_CHECK_EN
        return adr[31:11] == 21'(32'h0100_0000 >> 11);
`else
        return adr != 32'hFFFF_FFFF || adr == 32'hFFFF_FFFF;
`endif
    endfunction

    // every cycle: outputs against what the model scheduled for that cycle
    always @(negedge clk) begin
        if (wb_rst_i) begin
            last_rd = 32'h0;
        end else if (chk_en) begin
            if (exp_rd.exists(cyc_n)) last_rd = exp_rd[cyc_n];
            chk("ack", {31'h0, wbs_ack_o}, {31'h0, exp_ack.exists(cyc_n) == 1});
            chk("err", {31'h0, wbs_err_o}, {31'h0, exp_err.exists(cyc_n) == 1});
            chk("dat_o", wbs_dat_o, last_rd);
            if (exp_strobe.exists(cyc_n)) begin
                chk("csb", {31'h0, sram_csb}, 32'h0);
                chk("web", {31'h0, sram_web}, {31'h0, exp_strobe[cyc_n].web});
                chk("wmask", {28'h0, sram_wmask}, {28'h0, exp_strobe[cyc_n].wmask});
                chk("addr", {23'h0, sram_addr}, {23'h0, exp_strobe[cyc_n].addr});
                chk("din", sram_din, exp_strobe[cyc_n].din);
            end else begin
                chk("csb_idle", {31'h0, sram_csb}, 32'h1);
            end
        end
    end

    // one Wishbone transfer starting in the current cycle; schedules its expected effects
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit abort, input bit hold);
        int t;
        bit ok;
        logic [8:0] w;
        t  = cyc_n;
        ok = addr_ok(adr);
        w  = adr[10:2];
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        if (ok) begin
            exp_strobe[t] = '{~we, we ? sel : 4'h0, w, dat};
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
                exp_ack[t+1] = 1'b1;
            end else if (!abort) begin
                exp_ack[t+2] = 1'b1;
                exp_rd[t+2]  = ref_mem[w];
            end
        end else begin
            exp_err[t+1] = 1'b1;
        end
        #1;
        p_csb = sram_csb; p_web = sram_web; p_wmask = sram_wmask; p_addr = sram_addr;
        if (ok && !we && abort) begin
            @(posedge clk); #1;
            wbs_cyc_i = 1'b0;
            @(posedge clk); #1;
            if (!hold) wbs_stb_i = 1'b0;
            lat = 0;
            return;
        end
        lat = -1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o || wbs_err_o) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), (ok && !we) ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        if (!hold) begin
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
        end
    endtask

    initial begin
        int t;
        logic [31:0] adr;
        bit hold;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_err", {31'h0, wbs_err_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_csb", {31'h0, sram_csb}, 32'h1);
        chk("rst_web", {31'h0, sram_web}, 32'h1);
        chk("rst_wmask", {28'h0, sram_wmask}, 32'h0);
        wb_rst_i = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        xfer(1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
        chk("t2_csb", {31'h0, p_csb}, 32'h0);
        chk("t2_web", {31'h0, p_web}, 32'h0);
        chk("t2_wmask", {28'h0, p_wmask}, 32'hF);
        chk("t2_addr", {23'h0, p_addr}, 32'd4);
        chk("t2_lat", 32'(lat), 32'd1);
        xfer(1'b0, 32'h0100_0010, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("t3_lat", 32'(lat), 32'd2);
        chk("t3_dat", wbs_dat_o, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h0100_0010, 32'h1122_3344, 4'b0010, 1'b0, 1'b0);
        xfer(1'b0, 32'h0100_0010, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("t4_dat", wbs_dat_o, 32'hDEAD_33EF);
        xfer(1'b1, 32'h0100_0000, 32'h0000_AAAA, 4'hF, 1'b0, 1'b0);
        xfer(1'b1, 32'h0100_07FC, 32'h5555_0001, 4'hF, 1'b0, 1'b0);
        xfer(1'b0, 32'h0100_0000, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("t5_dat0", wbs_dat_o, 32'h0000_AAAA);
        xfer(1'b0, 32'h0100_07FC, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("t5_addr511", {23'h0, p_addr}, 32'd511);
        chk("t5_dat511", wbs_dat_o, 32'h5555_0001);
        xfer(1'b0, 32'h0200_0000, 32'h0, 4'hF, 1'b0, 1'b0);
`ifdef WB_SRAM_ADDR_CHECK_EN
        chk("t6_csb", {31'h0, p_csb}, 32'h1);
        chk("t6_dat", wbs_dat_o, 32'h5555_0001);
`else
        chk("t6_csb", {31'h0, p_csb}, 32'h0);
        chk("t6_dat", wbs_dat_o, 32'h0000_AAAA);
`endif

        t = cyc_n;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h0100_0010; wbs_dat_i = 32'h0; wbs_sel_i = 4'hF;
        exp_strobe[t] = '{1'b1, 4'h0, 9'd4, 32'h0};
        @(posedge clk); #2;
        chk_en = 1'b0;
        wb_rst_i = 1'b1;
        #1;
        chk("t1_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("t1_err", {31'h0, wbs_err_o}, 32'h0);
        chk("t1_dat", wbs_dat_o, 32'h0);
        chk("t1_csb", {31'h0, sram_csb}, 32'h1);
        @(posedge clk); #1;
        exp_strobe.delete(); exp_ack.delete(); exp_err.delete(); exp_rd.delete();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        wb_rst_i = 1'b0;
        chk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            logic we;
            we   = 1'($urandom % 2);
            hold = 1'($urandom % 2);
            adr  = {($urandom % 4 == 0) ? 21'($urandom) : 21'(32'h0100_0000 >> 11),
                    9'($urandom % 512), 2'($urandom % 4)};
            xfer(we, adr, $urandom, 4'($urandom % 16), !we && ($urandom % 8 == 0), hold);
            if (!hold) begin
                repeat ($urandom % 3) begin
                    wbs_cyc_i = 1'($urandom % 2);
                    wbs_stb_i = wbs_cyc_i ? 1'b0 : 1'($urandom % 2);
                    @(posedge clk); #1;
                end
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
